// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: 1/2/4-byte accesses over an 8-bit memory port, with
// sign/zero extension of loads. Defining LSU_MISALIGN_TRAP_EN makes misaligned half/word accesses errors.
module load_store_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic [2:0]  req_ctrl,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [2:0]  ctrl_q;
    logic [1:0]  idx_q;
    logic [31:0] data_q;
    logic        err_q;

    // Byte count per funct3; 0 marks an unsupported encoding.
    function automatic logic [2:0] byte_count(input logic [2:0] ctrl);
        case (ctrl)
            3'b000, 3'b100: byte_count = 3'd1;
            3'b001, 3'b101: byte_count = 3'd2;
            3'b010:         byte_count = 3'd4;
            default:        byte_count = 3'd0;
        endcase
    endfunction

    logic [2:0]  req_n;
    logic [32:0] req_last;
    logic        req_misalign;
    logic        req_err_d;
    logic [1:0]  last_idx;

    always_comb begin
        req_n    = byte_count(req_ctrl);
        // 33-bit sum so addresses near 2^32 cannot wrap into range.
        req_last = {1'b0, req_addr} + {30'd0, req_n} - 33'd1;
`ifdef LSU_MISALIGN_TRAP_EN
        req_misalign = ((req_n == 3'd2) && req_addr[0]) ||
                       ((req_n == 3'd4) && (req_addr[1:0] != 2'b00));
`else
        req_misalign = 1'b0;
`endif
        req_err_d = (req_n == 3'd0) || (req_last >= 33'(MEM_BYTES)) || req_misalign;
        last_idx  = 2'(byte_count(ctrl_q) - 3'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ctrl_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        we_q    <= req_we;
                        ctrl_q  <= req_ctrl;
                        idx_q   <= '0;
                        data_q  <= '0;
                        err_q   <= req_err_d;
                        state_q <= req_err_d ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) data_q[8*idx_q +: 8] <= mem_rdata;
                    if (idx_q == last_idx) state_q <= RESP;
                    else                   idx_q   <= idx_q + 2'd1;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // State is forced to IDLE during reset, so only req_ready needs rst_n gating.
    assign req_ready = rst_n && (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = (state_q == RESP) && err_q;
    assign mem_we    = (state_q == ACCESS) && we_q;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ACCESS) begin
            mem_addr  = addr_q + {30'd0, idx_q};
            mem_wdata = wdata_q[8*idx_q +: 8];
        end
    end

    always_comb begin
        rsp_rdata = '0;
        if ((state_q == RESP) && !we_q && !err_q) begin
            case (ctrl_q)
                3'b000:  rsp_rdata = {{24{data_q[7]}}, data_q[7:0]};
                3'b001:  rsp_rdata = {{16{data_q[15]}}, data_q[15:0]};
                3'b100:  rsp_rdata = {24'd0, data_q[7:0]};
                3'b101:  rsp_rdata = {16'd0, data_q[15:0]};
                default: rsp_rdata = data_q;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random requests scored against a
// byte-array memory model that computes results directly from the access rules.
module tb_load_store_unit;

    localparam int MB = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [2:0]  req_ctrl;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    logic [7:0] mem     [0:MB-1];
    logic [7:0] ref_mem [0:MB-1];

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .req_ctrl(req_ctrl),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = (mem_addr < 32'(MB)) ? mem[mem_addr[9:0]] : 8'h00;

    // Sole writer of the DUT-side memory: initial fill, then byte writes at each edge.
    initial begin
        for (int i = 0; i < MB; i++) mem[i] = 8'(i * 73 + 19);
        forever begin
            @(posedge clk);
            if (mem_we) begin
                if (mem_addr < 32'(MB)) mem[mem_addr[9:0]] = mem_wdata;
                wr_cnt = wr_cnt + 1;
            end
        end
    end

    function automatic int nbytes(input logic [2:0] c);
        if (c == 3'b000 || c == 3'b100) return 1;
        if (c == 3'b001 || c == 3'b101) return 2;
        if (c == 3'b010) return 4;
        return 0;
    endfunction

    task automatic run_req(input logic [31:0] a, input logic [31:0] wd, input logic we,
                           input logic [2:0] c, output logic [31:0] got);
        int          n;
        longint      last;
        bit          e_err;
        longint      v;
        logic [31:0] e_data;
        int          e_lat;
        int          e_wr;
        int          snap;
        int          lat;
        bit          seen;
        n     = nbytes(c);
        last  = longint'(a) + n - 1;
        e_err = (n == 0) || (last >= MB);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) e_err = 1'b1;
`endif
        e_data = 32'd0;
        if (!e_err && !we) begin
            v = 0;
            for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[int'(a) + i]) << (8 * i));
            if (c[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
                v = v - (longint'(1) << (8 * n));
            e_data = 32'(v);
        end
        if (!e_err && we)
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
        e_lat = e_err ? 1 : n + 1;
        e_wr  = (!e_err && we) ? n : 0;

        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: ready=%b valid=%b, required ready=1 valid=0", req_ready, rsp_valid);
        end
        snap = wr_cnt;
        req_valid = 1'b1; req_addr = a; req_wdata = wd; req_we = we; req_ctrl = c;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom; req_wdata = $urandom;
        req_we    = 1'($urandom); req_ctrl = 3'($urandom);
        lat  = 0;
        seen = 1'b0;
        got  = 32'hx;
        while (lat < 10 && !seen) begin
            @(negedge clk);
            lat++;
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                got  = rsp_rdata;
            end else if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                checks++; errors++;
                $display("FAIL busy_outputs: rdata=%h err=%b ready=%b, required 0/0/0", rsp_rdata, rsp_err, req_ready);
            end
        end
        checks++;
        if (!seen || lat != e_lat) begin
            errors++;
            $display("FAIL latency a=%h c=%b we=%b: seen=%b cycle=%0d, required cycle %0d", a, c, we, seen, lat, e_lat);
        end
        checks++;
        if (rsp_err !== e_err || got !== e_data) begin
            errors++;
            $display("FAIL response a=%h c=%b we=%b: err=%b rdata=%h, required err=%b rdata=%h", a, c, we, rsp_err, got, e_err, e_data);
        end
        checks++;
        if (wr_cnt - snap != e_wr) begin
            errors++;
            $display("FAIL write_count a=%h c=%b we=%b: %0d writes, required %0d", a, c, we, wr_cnt - snap, e_wr);
        end
        if (e_wr != 0)
            for (int i = 0; i < n; i++) begin
                checks++;
                if (mem[int'(a) + i] !== ref_mem[int'(a) + i]) begin
                    errors++;
                    $display("FAIL store_byte @%0h: %h, required %h", int'(a) + i, mem[int'(a) + i], ref_mem[int'(a) + i]);
                end
            end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
        req_we = 1'b1; req_ctrl = 3'b010;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0 ||
            mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 8'd0 || wr_cnt != 0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b err=%b rdata=%h we=%b addr=%h wd=%h writes=%0d, required all 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata, mem_we, mem_addr, mem_wdata, wr_cnt);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: %b, required 1", req_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] got;
        run_req(32'h10, 32'hA1B2C3D4, 1'b1, 3'b010, got);
        checks++;
        if ({mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]} !== 32'hA1B2C3D4) begin
            errors++;
            $display("FAIL word_store: %h, required A1B2C3D4", {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]});
        end
        run_req(32'h13, 32'h0, 1'b0, 3'b000, got);
        checks++;
        if (got !== 32'hFFFFFFA1) begin errors++; $display("FAIL lb_0x13: %h, required FFFFFFA1", got); end
        run_req(32'h13, 32'h0, 1'b0, 3'b100, got);
        checks++;
        if (got !== 32'h000000A1) begin errors++; $display("FAIL lbu_0x13: %h, required 000000A1", got); end
        run_req(32'h12, 32'h0, 1'b0, 3'b001, got);
        checks++;
        if (got !== 32'hFFFFA1B2) begin errors++; $display("FAIL lh_0x12: %h, required FFFFA1B2", got); end
        run_req(32'h10, 32'h0, 1'b0, 3'b010, got);
        checks++;
        if (got !== 32'hA1B2C3D4) begin errors++; $display("FAIL lw_0x10: %h, required A1B2C3D4", got); end
        run_req(32'h3FE, 32'h0, 1'b0, 3'b010, got);
        run_req(32'h3FC, 32'h0, 1'b0, 3'b010, got);
        run_req(32'h3FF, 32'h0, 1'b0, 3'b101, got);
        run_req(32'h3FF, 32'h0, 1'b0, 3'b100, got);
        run_req(32'hFFFF_FFFE, 32'h0, 1'b0, 3'b010, got);
        run_req(32'h20, 32'h55667788, 1'b1, 3'b011, got);
        run_req(32'h20, 32'h55667788, 1'b1, 3'b110, got);
        run_req(32'h20, 32'h55667788, 1'b0, 3'b111, got);
        run_req(32'h21, 32'h0, 1'b0, 3'b010, got);
        run_req(32'h31, 32'h0000BEEF, 1'b1, 3'b001, got);
        run_req(32'h31, 32'h0, 1'b0, 3'b101, got);
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] wd;
        int          snap;
        wd = 32'h11223344;
        @(negedge clk);
        snap = wr_cnt;
        req_valid = 1'b1; req_addr = 32'h40; req_wdata = wd; req_we = 1'b1; req_ctrl = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: we=%b valid=%b ready=%b, required 0/0/0", mem_we, rsp_valid, req_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_mem[16'h40] = wd[7:0];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL after_abort: valid=%b ready=%b, required 0/1", rsp_valid, req_ready);
            end
        end
        checks++;
        if (wr_cnt - snap != 1 || mem[16'h40] !== 8'h44 || mem[16'h41] !== ref_mem[16'h41] ||
            mem[16'h42] !== ref_mem[16'h42] || mem[16'h43] !== ref_mem[16'h43]) begin
            errors++;
            $display("FAIL abort_bytes: writes=%0d mem40..43=%h %h %h %h, required 1 write of 44 only",
                     wr_cnt - snap, mem[16'h40], mem[16'h41], mem[16'h42], mem[16'h43]);
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        logic [31:0] a;
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(1016, 1030));
                1:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: a = 32'($urandom_range(0, 1023));
            endcase
            run_req(a, $urandom, 1'($urandom), 3'($urandom_range(0, 7)), got);
        end
    endtask

    task automatic test_final_memory();
        int bad;
        bad = 0;
        for (int i = 0; i < MB; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL final_memory: %0d bytes differ, required 0", bad);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < MB; i++) ref_mem[i] = 8'(i * 73 + 19);
        test_reset();
        test_directed();
        test_reset_mid_access();
        test_random();
        test_final_memory();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
